// File: rtl/arf_sequencer.sv
// arf_sequencer: expands one pointer op into per-cycle ARF/memory control steps.
// Define ARF_STACK_BOUNDS_EN to add stack depth tracking with a Fault pulse.
module arf_sequencer #(
  parameter logic [15:0] STACK_TOP   = 16'h07FF,
  parameter int          STACK_DEPTH = 256
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  input  logic [2:0]  ReqOp,
  input  logic [15:0] ReqTarget,
  output logic        ReqReady,
  output logic        Done,
  output logic        Fault,
  output logic [15:0] TargetQ,
  output logic [1:0]  ISrc,
  output logic [2:0]  RegSel,
  output logic [2:0]  FunSel,
  output logic [1:0]  OutCSel,
  output logic [1:0]  OutDSel,
  output logic        MemRd,
  output logic        MemWr
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_FETCH = 3'b001;
  localparam logic [2:0] OP_PUSH  = 3'b010;
  localparam logic [2:0] OP_POP   = 3'b011;
  localparam logic [2:0] OP_CALL  = 3'b100;
  localparam logic [2:0] OP_RET   = 3'b101;
  localparam logic [2:0] OP_JUMP  = 3'b110;
  localparam logic [2:0] OP_INIT  = 3'b111;

`ifdef ARF_STACK_BOUNDS_EN
  localparam logic FAULT_EN = 1'b1;
`else
  localparam logic FAULT_EN = 1'b0;
`endif

  typedef enum logic [4:0] {
    IDLE, NOP1, FE1, FE2, PU1, PU2, PO1, PO2,
    CA1, CA2, CA3, RE1, RE2, RE3, JU1, IN1, IN2, FLT
  } state_t;

  typedef struct packed {
    logic [2:0] regsel;
    logic [2:0] funsel;
    logic [1:0] outc;
    logic [1:0] outd;
    logic [1:0] isrc;
    logic       rd;
    logic       wr;
    logic       done;
    logic       fault;
  } ctl_t;

  localparam ctl_t IDLE_CTL = '{
    regsel: 3'b111, funsel: 3'b000, outc: 2'b00, outd: 2'b00,
    isrc: 2'b00, rd: 1'b0, wr: 1'b0, done: 1'b0, fault: 1'b0
  };

  state_t state, nxt;
  ctl_t   ctl;
  logic   bad;

  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = IDLE_CTL;
    case (s)
      NOP1: c.done = 1'b1;
      FE1: begin
        c.outc = 2'b00;
        c.rd   = 1'b1;
      end
      FE2: begin
        c.regsel = 3'b011;
        c.funsel = 3'b001;
        c.done   = 1'b1;
      end
      PU1: begin
        c.outd = 2'b11;
        c.wr   = 1'b1;
      end
      PU2: begin
        c.regsel = 3'b110;
        c.funsel = 3'b000;
        c.done   = 1'b1;
      end
      PO1, RE1: begin
        c.regsel = 3'b110;
        c.funsel = 3'b001;
      end
      PO2: begin
        c.outd = 2'b11;
        c.rd   = 1'b1;
        c.done = 1'b1;
      end
      CA1: begin
        c.outd = 2'b11;
        c.outc = 2'b00;
        c.wr   = 1'b1;
      end
      CA2: begin
        c.regsel = 3'b110;
        c.funsel = 3'b000;
      end
      CA3, JU1: begin
        c.regsel = 3'b011;
        c.funsel = 3'b010;
        c.isrc   = 2'b00;
        c.done   = 1'b1;
      end
      RE2: begin
        c.outd = 2'b11;
        c.rd   = 1'b1;
      end
      RE3: begin
        c.regsel = 3'b011;
        c.funsel = 3'b010;
        c.isrc   = 2'b01;
        c.done   = 1'b1;
      end
      IN1: begin
        c.regsel = 3'b001;
        c.funsel = 3'b011;
      end
      IN2: begin
        c.regsel = 3'b110;
        c.funsel = 3'b010;
        c.isrc   = 2'b10;
        c.done   = 1'b1;
      end
      FLT: begin
        c.done  = 1'b1;
        c.fault = FAULT_EN;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (ReqValid) begin
          if (bad) begin
            nxt = FLT;
          end else begin
            case (ReqOp)
              OP_NOP:   nxt = NOP1;
              OP_FETCH: nxt = FE1;
              OP_PUSH:  nxt = PU1;
              OP_POP:   nxt = PO1;
              OP_CALL:  nxt = CA1;
              OP_RET:   nxt = RE1;
              OP_JUMP:  nxt = JU1;
              default:  nxt = IN1;
            endcase
          end
        end
      end
      FE1:     nxt = FE2;
      PU1:     nxt = PU2;
      PO1:     nxt = PO2;
      CA1:     nxt = CA2;
      CA2:     nxt = CA3;
      RE1:     nxt = RE2;
      RE2:     nxt = RE3;
      IN1:     nxt = IN2;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they track the state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      ctl      <= IDLE_CTL;
      ReqReady <= 1'b1;
      TargetQ  <= 16'h0000;
    end else begin
      state    <= nxt;
      ctl      <= decode(nxt);
      ReqReady <= (nxt == IDLE);
      if (ReqReady && ReqValid) begin
        TargetQ <= ReqTarget;
      end
    end
  end

  assign RegSel  = ctl.regsel;
  assign FunSel  = ctl.funsel;
  assign OutCSel = ctl.outc;
  assign OutDSel = ctl.outd;
  assign ISrc    = ctl.isrc;
  assign MemRd   = ctl.rd;
  assign MemWr   = ctl.wr;
  assign Done    = ctl.done;
  assign Fault   = ctl.fault;

`ifdef ARF_STACK_BOUNDS_EN
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  logic [DW-1:0] depth;
  logic          grow;
  logic          shrink;

  assign grow   = (ReqOp == OP_PUSH) || (ReqOp == OP_CALL);
  assign shrink = (ReqOp == OP_POP) || (ReqOp == OP_RET);
  assign bad    = (grow && depth == FULL) || (shrink && depth == '0);

  // Depth moves only in the Done step of a completed stack op.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      depth <= '0;
    end else begin
      case (state)
        IN2:      depth <= '0;
        PU2, CA3: depth <= depth + DW'(1);
        PO2, RE3: depth <= depth - DW'(1);
        default:  ;
      endcase
    end
  end

  logic unused_top;
  assign unused_top = ^STACK_TOP;
`else
  assign bad = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^{STACK_TOP, STACK_DEPTH};
`endif

endmodule

// File: tb/tb_arf_sequencer.sv
// tb_arf_sequencer: scoreboard of per-step control words plus a small ARF/memory model.
// Build with ARF_STACK_BOUNDS_EN to exercise the fault path.
module tb_arf_sequencer;

  localparam logic [15:0] TOP   = 16'h07FF;
  localparam int          DEPTH = 2;

  localparam logic [2:0] NOP = 3'd0, FETCH = 3'd1, PUSH = 3'd2, POP = 3'd3;
  localparam logic [2:0] CALL = 3'd4, RET = 3'd5, JUMP = 3'd6, INIT = 3'd7;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        ReqValid = 1'b0;
  logic [2:0]  ReqOp = 3'd0;
  logic [15:0] ReqTarget = 16'h0;
  logic        ReqReady, Done, Fault, MemRd, MemWr;
  logic [15:0] TargetQ;
  logic [1:0]  ISrc, OutCSel, OutDSel;
  logic [2:0]  RegSel, FunSel;

  arf_sequencer #(.STACK_TOP(TOP), .STACK_DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqOp(ReqOp),
    .ReqTarget(ReqTarget), .ReqReady(ReqReady), .Done(Done), .Fault(Fault),
    .TargetQ(TargetQ), .ISrc(ISrc), .RegSel(RegSel), .FunSel(FunSel),
    .OutCSel(OutCSel), .OutDSel(OutDSel), .MemRd(MemRd), .MemWr(MemWr)
  );

  always #5 Clock = ~Clock;

  int checks = 0, errors = 0;
  int done_cnt = 0, acc_cnt = 0, fault_cnt = 0, depth_m = 0;
  logic [15:0] sb[$];
  logic [15:0] pc = 16'h0000, ar = 16'hBEEF, sp = TOP, mem_q = 16'h0;
  logic [15:0] mem[logic [15:0]];
  logic [15:0] word;

  assign word = {RegSel, FunSel, OutCSel, OutDSel, ISrc, MemRd, MemWr, Done, Fault};

  localparam logic [15:0] IDLE_W = {3'b111, 3'b000, 6'b0, 4'b0};

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] w(
    input logic [2:0] rs, input logic [2:0] fs, input logic [1:0] oc,
    input logic [1:0] od, input logic [1:0] is, input logic rd,
    input logic wr, input logic dn, input logic ft);
    return {rs, fs, oc, od, is, rd, wr, dn, ft};
  endfunction

  task automatic push_steps(input logic [2:0] op, input bit flt);
    if (flt) begin
      sb.push_back(w(3'b111, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
    end else begin
      case (op)
        NOP: sb.push_back(w(3'b111, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        FETCH: begin
          sb.push_back(w(3'b111, 3'b000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
          sb.push_back(w(3'b011, 3'b001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        PUSH: begin
          sb.push_back(w(3'b111, 3'b000, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
          sb.push_back(w(3'b110, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        POP: begin
          sb.push_back(w(3'b110, 3'b001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
          sb.push_back(w(3'b111, 3'b000, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0));
        end
        CALL: begin
          sb.push_back(w(3'b111, 3'b000, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
          sb.push_back(w(3'b110, 3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
          sb.push_back(w(3'b011, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        RET: begin
          sb.push_back(w(3'b110, 3'b001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
          sb.push_back(w(3'b111, 3'b000, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
          sb.push_back(w(3'b011, 3'b010, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        JUMP: sb.push_back(w(3'b011, 3'b010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        default: begin
          sb.push_back(w(3'b001, 3'b011, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
          sb.push_back(w(3'b110, 3'b010, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0));
        end
      endcase
    end
  endtask

  // Acceptance: decide fault vs full sequence and queue the expected steps.
  always @(posedge Clock) begin : mon
    bit flt;
    flt = 1'b0;
    if (!Reset && ReqValid && ReqReady) begin
`ifdef ARF_STACK_BOUNDS_EN
      if (((ReqOp == PUSH || ReqOp == CALL) && depth_m == DEPTH) ||
          ((ReqOp == POP || ReqOp == RET) && depth_m == 0))
        flt = 1'b1;
`endif
      if (!flt) begin
        case (ReqOp)
          PUSH, CALL: depth_m++;
          POP, RET:   depth_m--;
          INIT:       depth_m = 0;
          default:    ;
        endcase
      end
      push_steps(ReqOp, flt);
      acc_cnt++;
    end
  end

  function automatic logic [15:0] rd_reg(input logic [1:0] s);
    case (s)
      2'b10:   return ar;
      2'b11:   return sp;
      default: return pc;
    endcase
  endfunction

  function automatic logic [15:0] fn(input logic [15:0] q, input logic [15:0] iv);
    case (FunSel)
      3'b000:  return q - 16'd1;
      3'b001:  return q + 16'd1;
      3'b010:  return iv;
      3'b011:  return 16'h0;
      default: return q;
    endcase
  endfunction

  // ARF and memory driven by the sequencer's strobes.
  always @(posedge Clock) begin : arf
    logic [15:0] iv;
    iv = (ISrc == 2'b00) ? TargetQ : (ISrc == 2'b01) ? mem_q : TOP;
    if (!Reset) begin
      if (!RegSel[2]) pc <= fn(pc, iv);
      if (!RegSel[1]) ar <= fn(ar, iv);
      if (!RegSel[0]) sp <= fn(sp, iv);
      if (MemWr) mem[rd_reg(OutDSel)] = rd_reg(OutCSel);
      if (MemRd) mem_q <= mem.exists(rd_reg(OutDSel)) ? mem[rd_reg(OutDSel)] : 16'h0;
    end
  end

  always @(negedge Clock) begin : chk
    logic [15:0] exp;
    if (!Reset) begin
      if (Done) done_cnt++;
      if (Fault) fault_cnt++;
      if (!ReqReady) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 16'hFFFF;
        check("step", 32'(word), 32'(exp));
      end else begin
        check("idle", 32'(word), 32'(IDLE_W));
        check("sb_drained", 32'(sb.size()), 32'd0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!ReqReady && n < 20) begin
      @(negedge Clock);
      n++;
    end
    check("idle_timeout", 32'(ReqReady), 32'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [15:0] tgt);
    @(negedge Clock);
    ReqValid = 1'b1;
    ReqOp = op;
    ReqTarget = tgt;
    @(negedge Clock);
    ReqValid = 1'b0;
    wait_idle();
  endtask

  function automatic logic [15:0] mrd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'hDEAD;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc0, done0, f0;
    repeat (2) @(negedge Clock);
    check("rst_word", 32'(word), 32'(IDLE_W));
    check("rst_tq", 32'(TargetQ), 32'h0);
    check("rst_rdy", 32'(ReqReady), 32'd1);
    Reset = 1'b0;

    // Reset in CALL step 2 aborts with no Done.
    @(negedge Clock);
    ReqValid = 1'b1;
    ReqOp = CALL;
    ReqTarget = 16'h0300;
    @(negedge Clock);
    ReqValid = 1'b0;
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    sb.delete();
    depth_m = 0;
    #1;
    check("mid_regsel", 32'(RegSel), 32'h7);
    check("mid_memwr", 32'(MemWr), 32'd0);
    check("mid_rdy", 32'(ReqReady), 32'd1);
    check("mid_done", 32'(Done), 32'd0);
    check("mid_tq", 32'(TargetQ), 32'h0);
    @(negedge Clock);
    #1 Reset = 1'b0;
    acc0 = acc_cnt;
    done0 = done_cnt;

    run_op(CALL, 16'h0100);
    check("call0_pc", 32'(pc), 32'h0100);
    check("call0_sp", 32'(sp), 32'h07FE);
    check("call0_tq", 32'(TargetQ), 32'h0100);

    run_op(INIT, 16'h0);
    check("init_pc", 32'(pc), 32'h0);
    check("init_ar", 32'(ar), 32'h0);
    check("init_sp", 32'(sp), 32'h07FF);

    run_op(NOP, 16'h0);
    run_op(JUMP, 16'h0010);
    check("jump_pc", 32'(pc), 32'h0010);
    run_op(FETCH, 16'h0);
    check("fetch_pc", 32'(pc), 32'h0011);

    run_op(CALL, 16'h0200);
    check("call_mem", 32'(mrd(16'h07FF)), 32'h0011);
    check("call_sp", 32'(sp), 32'h07FE);
    check("call_pc", 32'(pc), 32'h0200);
    run_op(RET, 16'h0);
    check("ret_pc", 32'(pc), 32'h0011);
    check("ret_sp", 32'(sp), 32'h07FF);

    // ReqValid held high while ReqOp toggles every cycle.
    for (int i = 0; i < 16; i++) begin
      @(negedge Clock);
      ReqValid = 1'b1;
      ReqOp = (i % 2 == 1) ? POP : PUSH;
    end
    @(negedge Clock);
    ReqValid = 1'b0;
    wait_idle();

    f0 = fault_cnt;
    run_op(INIT, 16'h0);
    run_op(POP, 16'h0);
`ifdef ARF_STACK_BOUNDS_EN
    check("pop_empty_sp", 32'(sp), 32'h07FF);
`else
    check("pop_empty_sp", 32'(sp), 32'h0800);
`endif
    run_op(PUSH, 16'h0);
    run_op(PUSH, 16'h0);
`ifdef ARF_STACK_BOUNDS_EN
    check("push2_sp", 32'(sp), 32'h07FD);
`else
    check("push2_sp", 32'(sp), 32'h07FE);
`endif
    run_op(PUSH, 16'h0);
    check("push3_sp", 32'(sp), 32'h07FD);
`ifdef ARF_STACK_BOUNDS_EN
    check("fault_cnt", 32'(fault_cnt - f0), 32'd2);
`else
    check("fault_cnt", 32'(fault_cnt), 32'd0);
`endif

    check("done_vs_acc", 32'(done_cnt - done0), 32'(acc_cnt - acc0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arf_sequencer.md
Name: arf_sequencer

Overview:
- Multi-cycle controller that drives the control inputs of the address register file (PC/AR/SP) and the memory strobes.
- Accepts one pointer operation at a time (fetch, push, pop, call, return, jump, pointer init) over a valid/ready handshake and expands it into a fixed per-cycle sequence of RegSel/FunSel/OutCSel/OutDSel/ISrc/MemRd/MemWr.
- Sits between the instruction control unit and the ARF/memory interface.

Parameters:
- STACK_TOP, 16'h07FF, value loaded into SP by INIT.
- STACK_DEPTH, 256, maximum stack entries; used only with ARF_STACK_BOUNDS_EN.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- ReqValid  in  1  operation request valid
- ReqOp  in  3  000 NOP, 001 FETCH, 010 PUSH, 011 POP, 100 CALL, 101 RET, 110 JUMP, 111 INIT
- ReqTarget  in  16  jump/call target
- ReqReady  out  1  high only in IDLE
- Done  out  1  one-cycle pulse in the final step of an operation
- Fault  out  1  stack bounds fault pulse (0 without the optional feature)
- TargetQ  out  16  latched ReqTarget, feeds the ARF I mux
- ISrc  out  2  ARF I mux: 00 TargetQ, 01 memory data, 10 STACK_TOP
- RegSel  out  3  ARF enables, active-low: bit2 PC, bit1 AR, bit0 SP
- FunSel  out  3  ARF function: 000 Q-1, 001 Q+1, 010 load I, 011 clear
- OutCSel  out  2  00/01 PC, 10 AR, 11 SP
- OutDSel  out  2  same encoding as OutCSel
- MemRd  out  1  memory read strobe
- MemWr  out  1  memory write strobe

Behaviour:
- Clock and reset: one clock domain (Clock). Reset is asynchronous and active-high, named Reset.
- Moore FSM. All control outputs decode from the state register; TargetQ and the latched op are registers.
- Idle values:
  - RegSel=111, FunSel=000, OutCSel=00, OutDSel=00, ISrc=00.
  - MemRd=0, MemWr=0, Done=0, Fault=0.
- Reset values: FSM to IDLE, all outputs at idle values, TargetQ=0.
- Handshake:
  - A request is accepted on a rising edge with ReqValid=1 and ReqReady=1. ReqOp and ReqTarget are latched then.
  - ReqReady is high only in IDLE, so there is at least one IDLE cycle between operations.
- Step sequences after acceptance; Done is asserted in the last step listed:
  - NOP: S1 no enables.
  - FETCH:
    - S1 OutCSel=00, MemRd=1.
    - S2 RegSel=011, FunSel=001 (PC+1).
  - PUSH (SP points to next free slot; data comes from the external bus):
    - S1 OutDSel=11, MemWr=1.
    - S2 RegSel=110, FunSel=000 (SP-1).
  - POP:
    - S1 RegSel=110, FunSel=001 (SP+1).
    - S2 OutDSel=11, MemRd=1.
  - CALL:
    - S1 OutDSel=11, OutCSel=00 (PC as write data), MemWr=1.
    - S2 SP-1.
    - S3 RegSel=011, FunSel=010, ISrc=00 (PC <= TargetQ).
  - RET:
    - S1 SP+1.
    - S2 OutDSel=11, MemRd=1.
    - S3 RegSel=011, FunSel=010, ISrc=01 (PC <= memory data).
  - JUMP: S1 RegSel=011, FunSel=010, ISrc=00.
  - INIT:
    - S1 RegSel=001, FunSel=011 (clear PC and AR).
    - S2 RegSel=110, FunSel=010, ISrc=10 (SP <= STACK_TOP).
- The FSM returns to IDLE on the edge after the Done step.
- Exactly one of MemRd/MemWr, or neither, is asserted in any cycle. No step enables a register not listed.
- Reset mid-operation: the FSM goes to IDLE immediately and outputs drop to idle values asynchronously. Partial effects already clocked into the ARF are not undone. No Done is produced.
- ReqValid/ReqOp changes while busy are ignored.

Optional Feature:
- Macro: ARF_STACK_BOUNDS_EN.
- Enabled:
  - Internal depth counter, range 0..STACK_DEPTH, reset 0.
  - INIT clears it. PUSH/CALL increment it at Done. POP/RET decrement it at Done.
  - PUSH/CALL accepted while depth==STACK_DEPTH, or POP/RET accepted while depth==0:
    - Executes a single fault step with Fault=1 and Done=1 in the same cycle.
    - All enables are idle; no memory strobe; the counter is unchanged.
- Disabled:
  - No counter.
  - Fault is tied to 0.
  - All ops always execute their full sequence.

Test Plan:
- Reset asserted mid-CALL at S2 -> same-cycle RegSel=111, MemWr=0, ReqReady=1. No Done. Next CALL runs all 3 steps.
- INIT -> S1 RegSel=001/FunSel=011, S2 RegSel=110/FunSel=010/ISrc=10, Done in S2. ARF model SP=16'h07FF, PC=0, AR=0.
- FETCH from PC=0x0010 -> S1 MemRd=1/OutCSel=00, S2 PC+1. Model PC=0x0011. ReqReady low for 2 cycles, then high.
- CALL target 0x0200 with PC=0x0011, SP=0x07FF:
  - M[0x07FF]=0x0011, SP=0x07FE, PC=0x0200.
  - A following RET restores PC=0x0011 and SP=0x07FF.
- ReqValid held high with alternating PUSH/POP -> each op accepted only in IDLE. No overlapping strobes. Done count equals accepted count.
- With ARF_STACK_BOUNDS_EN and STACK_DEPTH=2:
  - Third PUSH -> Fault=1 and Done=1, no MemWr, SP unchanged.
  - POP after INIT -> Fault=1.
  - Without the macro, Fault stays 0 throughout.
